// File: rtl/tb_uart_stim_pkg.sv
// Shared definitions for the UART stimulus transmitter: FSM encodings,
// line levels and the per-state TXD decode.
package tb_uart_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  // Line level for a given state; in DATA the current shifter LSB goes out.
  function automatic logic line_level(input state_e st, input logic data_bit);
    logic lvl;
    case (st)
      ST_IDLE:  lvl = IDLE_LEVEL;
      ST_START: lvl = ~IDLE_LEVEL;
      ST_DATA:  lvl = data_bit;
      ST_STOP:  lvl = IDLE_LEVEL;
      default:  lvl = IDLE_LEVEL;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/tb_uart_stim_fifo.sv
// Byte FIFO feeding the serialiser: registered level, full/empty decoded
// from that level, read data presented combinationally at rptr.
module tb_uart_stim_fifo
  import tb_uart_stim_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [LW-1:0]    level_r;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      level_r <= {LW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wptr_r] <= wdata;
        wptr_r        <= wptr_r + PW'(1'b1);
      end
      if (pop) begin
        rptr_r <= rptr_r + PW'(1'b1);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + LW'(1'b1);
        2'b01:   level_r <= level_r - LW'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  assign rdata = mem_r[rptr_r];
  assign level = level_r;
  assign full  = (level_r == LW'(DEPTH));
  assign empty = (level_r == {LW{1'b0}});

endmodule

// File: rtl/tb_uart_stim_tx.sv
// Bench-side UART transmitter: bytes pushed over valid/ready are queued and
// serialised 8N1/8N2 onto TXD at CLKS_PER_BIT clocks per bit.
module tb_uart_stim_tx
  import tb_uart_stim_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic                          ENABLE,
  input  logic [7:0]                    DATA_IN,
  input  logic                          VALID,
  output logic                          READY,
  output logic                          TXD,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int             TW         = $clog2(CLKS_PER_BIT + 1);
  localparam int             LW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0]  BIT_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]  TIMER_ZERO = {TW{1'b0}};
  localparam logic           LAST_STOP  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic [2:0]     LAST_BIT   = 3'(DATA_BITS - 1);

  state_e        state_r, state_s;
  logic [TW-1:0] timer_r, timer_s;
  logic [2:0]    bit_idx_r, bit_idx_s;
  logic          stop_idx_r, stop_idx_s;
  logic [7:0]    shift_r, shift_s;
  logic          txd_r, busy_r;

  logic          push_s, pop_s, pop_ok_s, bit_end_s;
  logic [7:0]    fifo_rdata_s;
  logic [LW-1:0] fifo_level_s;
  logic          fifo_full_s, fifo_empty_s;

  assign push_s    = VALID & ~fifo_full_s;
  assign pop_ok_s  = ENABLE & ~fifo_empty_s;
  assign bit_end_s = (timer_r == TIMER_ZERO);

  tb_uart_stim_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETn),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (DATA_IN),
    .rdata (fifo_rdata_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state logic; a pop on the last stop cycle chains frames with no idle gap.
  always_comb begin
    state_s    = state_r;
    timer_s    = timer_r;
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    shift_s    = shift_r;
    pop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pop_ok_s) begin
          pop_s   = 1'b1;
          state_s = ST_START;
          timer_s = BIT_RELOAD;
          shift_s = fifo_rdata_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s   = ST_DATA;
          timer_s   = BIT_RELOAD;
          bit_idx_s = 3'd0;
        end else begin
          timer_s = timer_r - TW'(1'b1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          timer_s = BIT_RELOAD;
          if (bit_idx_r == LAST_BIT) begin
            state_s    = ST_STOP;
            stop_idx_s = 1'b0;
          end else begin
            shift_s   = {1'b0, shift_r[7:1]};
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          timer_s = timer_r - TW'(1'b1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (stop_idx_r == LAST_STOP) begin
            if (pop_ok_s) begin
              pop_s   = 1'b1;
              state_s = ST_START;
              timer_s = BIT_RELOAD;
              shift_s = fifo_rdata_s;
            end else begin
              state_s   = ST_IDLE;
              timer_s   = TIMER_ZERO;
              bit_idx_s = 3'd0;
            end
          end else begin
            stop_idx_s = stop_idx_r + 1'b1;
            timer_s    = BIT_RELOAD;
          end
        end else begin
          timer_s = timer_r - TW'(1'b1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = TIMER_ZERO;
      end
    endcase
  end

  // State, datapath and registered line outputs derived from the next state.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_r    <= ST_IDLE;
      timer_r    <= TIMER_ZERO;
      bit_idx_r  <= 3'd0;
      stop_idx_r <= 1'b0;
      shift_r    <= 8'h00;
      txd_r      <= IDLE_LEVEL;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      timer_r    <= timer_s;
      bit_idx_r  <= bit_idx_s;
      stop_idx_r <= stop_idx_s;
      shift_r    <= shift_s;
      txd_r      <= line_level(state_s, shift_s[0]);
      busy_r     <= (state_s != ST_IDLE);
    end
  end

  assign TXD        = txd_r;
  assign BUSY       = busy_r;
  assign READY      = ~fifo_full_s;
  assign FIFO_LEVEL = fifo_level_s;

endmodule

// File: tb/tb_tb_uart_stim_tx.sv
// Directed bench for tb_uart_stim_tx: one 8N1 instance at 4 clk/bit and one
// 8N2 instance at 2 clk/bit, every frame checked cycle by cycle.
module tb_tb_uart_stim_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable_a, valid_a, ready_a, txd_a, busy_a;
  logic [7:0] data_a;
  logic [2:0] level_a;
  logic       enable_b, valid_b, ready_b, txd_b, busy_b;
  logic [7:0] data_b;
  logic [2:0] level_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tb_uart_stim_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut_a (
    .CLK(clk), .RESETn(rst_n), .ENABLE(enable_a), .DATA_IN(data_a), .VALID(valid_a),
    .READY(ready_a), .TXD(txd_a), .BUSY(busy_a), .FIFO_LEVEL(level_a)
  );

  tb_uart_stim_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
    .CLK(clk), .RESETn(rst_n), .ENABLE(enable_b), .DATA_IN(data_b), .VALID(valid_b),
    .READY(ready_b), .TXD(txd_b), .BUSY(busy_b), .FIFO_LEVEL(level_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_enable(input int sel, input logic v);
    if (sel == 0) enable_a = v;
    else          enable_b = v;
  endtask

  function automatic logic txd_of(input int sel);
    return (sel == 0) ? txd_a : txd_b;
  endfunction

  // Waits (bounded) for a start bit, then checks every cycle of the frame.
  task automatic check_frame(input string tag, input int sel, input logic [7:0] exp,
                             input int cpb, input int stops, input int exp_wait,
                             input int drop_at);
    int         w   = 0;
    int         bad = 0;
    logic [7:0] rx  = 8'h00;
    logic       want;
    while (txd_of(sel) == 1'b1 && w < 200) begin
      cyc();
      w++;
    end
    check({tag, " wait"}, w, exp_wait);
    for (int j = 0; j < 9 + stops; j++) begin
      for (int c = 0; c < cpb; c++) begin
        if (j * cpb + c == drop_at) set_enable(sel, 1'b0);
        if (j == 0)      want = 1'b0;
        else if (j <= 8) want = exp[j-1];
        else             want = 1'b1;
        if (txd_of(sel) !== want) bad++;
        if (j >= 1 && j <= 8 && c == cpb / 2) rx[j-1] = txd_of(sel);
        cyc();
      end
    end
    check({tag, " byte"}, {24'h0, rx}, {24'h0, exp});
    check({tag, " shape"}, bad, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    enable_a = 1'b1; valid_a = 1'b0; data_a = 8'h00;
    enable_b = 1'b1; valid_b = 1'b0; data_b = 8'h00;
    cyc(2);
    check("rst txd",   32'(txd_a),   32'd1);
    check("rst busy",  32'(busy_a),  32'd0);
    check("rst level", 32'(level_a), 32'd0);
    check("rst ready", 32'(ready_a), 32'd1);
    rst_n = 1'b1;
    cyc(2);
    check("post rst txd_b", 32'(txd_b), 32'd1);

    // Single 0x55 frame: start bit one edge after the push.
    data_a = 8'h55; valid_a = 1'b1;
    cyc();
    valid_a = 1'b0;
    check("t1 level", 32'(level_a), 32'd1);
    check("t1 txd pre", 32'(txd_a), 32'd1);
    check_frame("t1 0x55", 0, 8'h55, 4, 1, 1, -1);
    check("t1 busy end", 32'(busy_a), 32'd0);
    check("t1 txd end",  32'(txd_a),  32'd1);

    // Three queued bytes go out back to back.
    enable_a = 1'b0; valid_a = 1'b1;
    data_a = 8'hA3; cyc();
    data_a = 8'h0F; cyc();
    data_a = 8'hFF; cyc();
    valid_a = 1'b0;
    check("t2 level", 32'(level_a), 32'd3);
    enable_a = 1'b1;
    check_frame("t2 0xA3", 0, 8'hA3, 4, 1, 1, -1);
    check_frame("t2 0x0F", 0, 8'h0F, 4, 1, 0, -1);
    check_frame("t2 0xFF", 0, 8'hFF, 4, 1, 0, -1);
    check("t2 busy end", 32'(busy_a), 32'd0);

    // Fill to full with ENABLE low, then drain.
    enable_a = 1'b0; valid_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_a = 8'(8'h10 + i);
      cyc();
    end
    valid_a = 1'b0;
    check("t3 level full", 32'(level_a), 32'd4);
    check("t3 ready full", 32'(ready_a), 32'd0);
    check("t3 txd idle",   32'(txd_a),   32'd1);
    check("t3 busy idle",  32'(busy_a),  32'd0);
    enable_a = 1'b1;
    cyc();
    check("t3 ready after pop", 32'(ready_a), 32'd1);
    check("t3 level after pop", 32'(level_a), 32'd3);
    check_frame("t3 0x10", 0, 8'h10, 4, 1, 0, -1);
    check_frame("t3 0x11", 0, 8'h11, 4, 1, 0, -1);
    check_frame("t3 0x12", 0, 8'h12, 4, 1, 0, -1);
    check_frame("t3 0x13", 0, 8'h13, 4, 1, 0, -1);
    check("t3 level end", 32'(level_a), 32'd0);

    // ENABLE dropped during data bit 3 of 0x81; 0x42 must wait.
    enable_a = 1'b1; valid_a = 1'b1;
    data_a = 8'h81; cyc();
    data_a = 8'h42; cyc();
    valid_a = 1'b0;
    check("t4 level", 32'(level_a), 32'd1);
    check_frame("t4 0x81", 0, 8'h81, 4, 1, 0, 17);
    check("t4 txd held", 32'(txd_a), 32'd1);
    cyc(20);
    check("t4 txd still idle", 32'(txd_a),   32'd1);
    check("t4 level kept",     32'(level_a), 32'd1);
    check("t4 busy idle",      32'(busy_a),  32'd0);
    enable_a = 1'b1;
    check_frame("t4 0x42", 0, 8'h42, 4, 1, 1, -1);

    // Asynchronous reset in the middle of data bit 0 of 0xAA.
    valid_a = 1'b1;
    data_a = 8'hAA; cyc();
    data_a = 8'hBB; cyc();
    valid_a = 1'b0;
    cyc(7);
    check("t5 txd low pre", 32'(txd_a), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5 async txd",   32'(txd_a),   32'd1);
    check("t5 async busy",  32'(busy_a),  32'd0);
    check("t5 async level", 32'(level_a), 32'd0);
    check("t5 async ready", 32'(ready_a), 32'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
    data_a = 8'h3C; valid_a = 1'b1;
    cyc();
    valid_a = 1'b0;
    check_frame("t5 0x3C", 0, 8'h3C, 4, 1, 1, -1);
    check("t5 level end", 32'(level_a), 32'd0);
    check("t5 busy end",  32'(busy_a),  32'd0);

    // Two stop bits at 2 clk/bit: 22-cycle frames, 4-cycle stop between them.
    enable_b = 1'b0; data_b = 8'h00; valid_b = 1'b1;
    cyc(2);
    valid_b = 1'b0;
    check("t6 level", 32'(level_b), 32'd2);
    enable_b = 1'b1;
    check_frame("t6 first", 1, 8'h00, 2, 2, 1, -1);
    check_frame("t6 second", 1, 8'h00, 2, 2, 0, -1);
    check("t6 busy end", 32'(busy_b), 32'd0);
    check("t6 txd end",  32'(txd_b),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tb_uart_stim_tx.md
Name: tb_uart_stim_tx

Overview:
Testbench-side UART stimulus transmitter that feeds serial data into the MCU UART receive pin (P1[0]). It is the upstream counterpart of the UART capture device.
- Bench tasks push bytes through a valid/ready interface into a small FIFO.
- The block serialises each byte as 8N1 (or 8N2) at a fixed clock-per-bit rate.
- It lets software RX paths and UART interrupts be exercised in the MCU testbench.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per serial bit; legal range 2..65535; must match MCU UART BAUDDIV.
FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
CLK  input  1  single clock for all logic (same clock as PCLK/XTAL1)
RESETn  input  1  reset, asynchronous assert, active-low
ENABLE  input  1  1 = frames may start; 0 = hold off new frames
DATA_IN  input  8  byte to transmit
VALID  input  1  DATA_IN valid
READY  output  1  FIFO can accept a byte
TXD  output  1  serial output to MCU RXD; idle high
BUSY  output  1  frame in progress
FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  bytes held in FIFO (excludes the byte in the shifter)

Behaviour:
- Clock and reset: one clock, CLK. Reset RESETn is asynchronous, active-low.
- Reset values: TXD=1, BUSY=0, FIFO_LEVEL=0, READY=1, state=IDLE, all counters and pointers 0.
- Reset mid-frame: TXD returns to 1 asynchronously; the partial frame and FIFO contents are discarded.
- Push: occurs when VALID & READY are sampled high at a CLK edge. DATA_IN is written at wptr; wptr wraps modulo FIFO_DEPTH.
- READY = (FIFO_LEVEL != FIFO_DEPTH), decoded from the registered level only.
- VALID while READY=0: no push. DATA_IN must be held by the source; the byte is never dropped.
- Pop: only in IDLE or on the last cycle of the last stop bit, when FIFO_LEVEL!=0 (registered) and ENABLE=1. The byte at rptr is loaded into the shifter; rptr wraps.
- Simultaneous push and pop: FIFO_LEVEL unchanged. Push when full is impossible (READY=0). Pop when empty is impossible.
- Latency: a byte accepted at edge k with the FIFO empty and IDLE is popped at edge k+1. TXD=0 (start bit) is driven from edge k+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TXD=1, BUSY=0; moves to START on pop.
  - START: TXD=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: TXD=shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right, index+1. After bit 7 → STOP.
  - STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final cycle: pop and go to START if a pop is allowed (no idle gap); else go to IDLE.
- BUSY=1 in START, DATA and STOP.
- Bit timer: a down-counter of width $clog2(CLKS_PER_BIT+1), reloaded to CLKS_PER_BIT-1 at every bit boundary.
- Frame length: exactly (9+STOP_BITS)*CLKS_PER_BIT cycles.
- ENABLE=0 mid-frame: the current frame completes unchanged; no new pop. The FIFO keeps filling until full.
- TXD is a registered output with no glitches.

Decomposition:
- Shared package/defines file tb_uart_stim_defs.v holds:
  - FSM state encodings: ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3.
  - Idle line level constant.
- One natural sub-module: tb_uart_stim_fifo, a synchronous FIFO with push/pop, level and full/empty flags. The serialiser FSM stays in the top.

Test Plan:
- Reset, then push 0x55 with CLKS_PER_BIT=4 → TXD starts low 1 cycle after the push. Levels over 4 cycles each: 0,1,0,1,0,1,0,1,0,1. Total 40 cycles, then idle high with BUSY=0.
- Push 0xA3, 0x0F, 0xFF back-to-back → three frames with no idle gap between the stop bit and the next start bit. The MCU UART (BAUDDIV=4) receives 0xA3, 0x0F, 0xFF in order.
- Hold VALID high with FIFO_DEPTH=4 and ENABLE=0 → 4 pushes accepted, then READY=0 and FIFO_LEVEL=4 with TXD idle. Raising ENABLE then starts transmission; READY=1 one cycle after the first pop.
- Drop ENABLE during bit 3 of 0x81 → that frame completes (stop high). The next queued byte waits until ENABLE=1.
- Assert RESETn=0 during the DATA state → TXD=1 and BUSY=0 immediately (before the next CLK edge), FIFO_LEVEL=0. A subsequent push of 0x3C transmits correctly.
- STOP_BITS=2, CLKS_PER_BIT=2, push 0x00 twice → each frame is 22 cycles, with the stop high for 4 cycles between frames.
